pwm_capture: RTL and testbench

//   Measures an incoming PWM waveform: period and high-time in clk cycles.

---
 rtl/pwm_capture_pkg.sv | 18 +
 rtl/pwm_capture_sync_edge.sv | 33 +++
 rtl/pwm_capture.sv | 90 +++++++++
 tb/tb_pwm_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_pkg: FSM state encoding and default sizing shared by the PWM capture and generator blocks.
`default_nettype none

package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    FIRST   = 2'd2,
    MEASURE = 2'd3
  } state_t;

  localparam int             DEF_W       = 32;
  localparam longint unsigned DEF_TIMEOUT = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous input, plus rise/fall detection.
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM signal in clk cycles,
// with a one-cycle valid strobe per period and a sticky timeout for a stuck line.
`default_nettype none

module pwm_capture
  import pwm_pkg::*;
#(
  parameter int              W       = DEF_W,
  parameter longint unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] period,
  output logic [W-1:0] width,
  output logic         valid,
  output logic         timeout,
  output logic         level
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TO_CNT  = W'(TIMEOUT);

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] hi;
  logic         rise;
  logic         fall;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      period  <= '0;
      width   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else if (!en || state == IDLE) begin
      // Results and the timeout flag survive a disable; only the running counts clear.
      state <= en ? ARM : IDLE;
      cnt   <= '0;
      hi    <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (rise)
        cnt <= W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      if (fall)
        hi <= cnt;

      // A rise always takes priority over a coincident timeout.
      if (rise) begin
        timeout <= 1'b0;
        case (state)
          ARM:     state <= FIRST;
          FIRST:   state <= MEASURE;
          MEASURE: begin
            period <= cnt;
            width  <= hi;
            valid  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (cnt == TO_CNT) begin
        timeout <= 1'b1;
        period  <= '0;
        width   <= '0;
        state   <= ARM;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture: a waveform-level model predicts each measurement.
`default_nettype none

module tb_pwm_capture;

  localparam int W  = 16;
  localparam int TO = 50;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         en     = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] width;
  logic         valid;
  logic         timeout;
  logic         level;

  pwm_capture #(.W(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pwm_in  (pwm_in),
    .period  (period),
    .width   (width),
    .valid   (valid),
    .timeout (timeout),
    .level   (level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int p;
    int w;
    int at;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  // Model state: rises seen since (re)arming, and the cycles at which the input last rose/fell.
  int nrise = 0;
  int prev_rise = 0;
  int prev_fall = 0;
  int last_p = 0;
  int last_w = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Input driven just after edge n is sampled at edge n+1; its measurement shows after edge n+3.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].at < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_valid: got none, expected valid at cycle %0d (now %0d)", q[0].at, cyc);
        void'(q.pop_front());
      end
      if (valid) begin
        exp_t e;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got valid at cycle %0d, expected none", cyc);
        end else begin
          e = q.pop_front();
          check("valid_cycle", cyc, e.at);
          check("period", period, e.p);
          check("width", width, e.w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rises 1 and 2 after arming only establish phase; every later rise closes a full period.
  task automatic rise_edge();
    int n;
    pwm_in = 1'b1;
    n = cyc;
    if (en) begin
      nrise++;
      if (nrise >= 3) begin
        last_p = n - prev_rise;
        last_w = prev_fall - prev_rise;
        q.push_back('{last_p, last_w, n + 3});
      end
    end
    prev_rise = n;
  endtask

  task automatic pulse(input int h, input int l, input bit chk_to);
    int n;
    rise_edge();
    n = cyc;
    for (int i = 0; i < h; i++) begin
      step();
      if (chk_to) check("timeout_clear", timeout, (cyc >= n + 3) ? 0 : 1);
    end
    pwm_in = 1'b0;
    prev_fall = cyc;
    repeat (l) step();
  endtask

  task automatic rand_pulses(input int k);
    int p, h;
    for (int i = 0; i < k; i++) begin
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      pulse(h, p - h, 1'b0);
    end
  endtask

  // Line is held at lvl since the last rise; timeout must appear exactly TO counts later.
  task automatic expect_timeout(input bit lvl);
    while (cyc < prev_rise + TO + 2) step();
    check("timeout_early", timeout, 0);
    step();
    check("timeout_set", timeout, 1);
    check("timeout_period", period, 0);
    check("timeout_width", width, 0);
    check("timeout_level", level, lvl);
    nrise  = 0;
    last_p = 0;
    last_w = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("rst_period", period, 0);
    check("rst_width", width, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_level", level, 0);
    step();
    rst_n = 1'b1;
    step();
    en = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 6; i++) pulse(3, 7, 1'b0);
    repeat (6) pulse(2, 5, 1'b0);
    repeat (4) pulse(5, 2, 1'b0);
    rand_pulses(20);
    repeat (6) pulse(1, 1, 1'b0);

    // Stuck high after a final rise.
    rise_edge();
    expect_timeout(1'b1);
    pwm_in = 1'b0;
    repeat (5) step();
    pulse(4, 6, 1'b1);
    rand_pulses(5);

    // Disable while measuring: no strobes, results hold.
    repeat (5) step();
    en = 1'b0;
    repeat (3) pulse(2, 4, 1'b0);
    check("hold_period", period, last_p);
    check("hold_width", width, last_w);
    en = 1'b1;
    nrise = 0;
    repeat (5) step();
    rand_pulses(6);

    // Stuck low.
    pulse(2, 3, 1'b0);
    expect_timeout(1'b0);
    pulse(4, 5, 1'b1);
    repeat (4) pulse(3, 4, 1'b0);

    // Asynchronous reset in the middle of a period.
    step();
    #2;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("midrst_period", period, 0);
    check("midrst_width", width, 0);
    check("midrst_valid", valid, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_level", level, 0);
    q.delete();
    step();
    rst_n = 1'b1;
    nrise = 0;
    repeat (5) step();
    rand_pulses(6);

    repeat (10) step();
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
